// File: rtl/csa_pkg.sv
// Shared definitions for the pipelined carry-select adder: block/stage count
// derivation and the parameter-legality predicate used at elaboration.
package csa_pkg;

  // Number of carry-select blocks across the operand.
  function automatic int unsigned calc_nb(input int unsigned width, input int unsigned blk_w);
    return width / blk_w;
  endfunction

  // Number of pipeline stages given the block count.
  function automatic int unsigned calc_ns(input int unsigned nb, input int unsigned blks_per_stg);
    return nb / blks_per_stg;
  endfunction

  // True when the width splits evenly into blocks and the blocks evenly into stages.
  function automatic bit cfg_ok(input int unsigned width, input int unsigned blk_w,
                                input int unsigned blks_per_stg);
    if (width == 0 || blk_w == 0 || blks_per_stg == 0) return 1'b0;
    if ((width % blk_w) != 0) return 1'b0;
    if (((width / blk_w) % blks_per_stg) != 0) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/csa_select_block.sv
// One carry-select block: two ripple-carry chains (carry-in 0 and 1) computed
// in parallel, with the true carry-in picking the result.
module csa_select_block #(
  parameter int unsigned BLK_W = 4
) (
  input  logic [BLK_W-1:0] a,
  input  logic [BLK_W-1:0] b,
  input  logic             cin,
  output logic [BLK_W-1:0] sum,
  output logic             cout
);

  logic [BLK_W-1:0] s0, s1;
  logic [BLK_W:0]   c0, c1;

  // Dual ripple chains, one assuming carry-in 0 and one assuming carry-in 1.
  always_comb begin
    c0[0] = 1'b0;
    c1[0] = 1'b1;
    for (int i = 0; i < BLK_W; i++) begin
      s0[i]   = a[i] ^ b[i] ^ c0[i];
      s1[i]   = a[i] ^ b[i] ^ c1[i];
      c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
      c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
    end
  end

  // Late-arriving carry-in selects between the precomputed results.
  always_comb begin
    sum  = cin ? s1 : s0;
    cout = cin ? c1[BLK_W] : c0[BLK_W];
  end

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready on both sides.
// Register 0 captures the operands (b pre-inverted for subtract); each of the
// NS stages then resolves BLKS_PER_STG blocks, the last one feeding the output
// register. Optional signed-overflow output: define CSA_PIPE_OVF_EN.
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned BLK_W        = 4,
  parameter int unsigned BLKS_PER_STG = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NB = calc_nb(WIDTH, BLK_W);
  localparam int unsigned NS = calc_ns(NB, BLKS_PER_STG);
  localparam int unsigned SW = BLK_W * BLKS_PER_STG;

  if (!cfg_ok(WIDTH, BLK_W, BLKS_PER_STG)) begin : g_cfg_err
    $error("csa_pipe_adder: WIDTH must split into BLK_W blocks grouped by BLKS_PER_STG");
  end

  // sum holds the bits resolved so far; a/b carry the operands (b already
  // inverted for subtract) so later stages can read their slices.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t           stage_q [NS];
  stage_t           stage_d [NS];
  logic [NS:0]      adv;
  logic [SW-1:0]    res_sum [NS];
  logic [NS-1:0]    res_cout;
  logic [WIDTH-1:0] fin_sum;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  // Per-stage carry-select chain over this stage's blocks.
  for (genvar k = 0; k < NS; k++) begin : g_stg
    logic [BLKS_PER_STG:0] c;
    assign c[0] = stage_q[k].carry;
    for (genvar j = 0; j < BLKS_PER_STG; j++) begin : g_blk
      localparam int unsigned blk_lsb = (k * BLKS_PER_STG + j) * BLK_W;
      csa_select_block #(
        .BLK_W(BLK_W)
      ) u_blk (
        .a   (stage_q[k].a[blk_lsb +: BLK_W]),
        .b   (stage_q[k].b[blk_lsb +: BLK_W]),
        .cin (c[j]),
        .sum (res_sum[k][j*BLK_W +: BLK_W]),
        .cout(c[j+1])
      );
    end
    assign res_cout[k] = c[BLKS_PER_STG];
  end

  // Ready chain from the consumer back to the input; a slot may load when it
  // is empty or its occupant moves on this cycle.
  always_comb begin
    adv     = '0;
    adv[NS] = !out_valid_q || out_ready;
    for (int k = NS - 1; k >= 0; k--) begin
      adv[k] = !stage_q[k].valid || adv[k+1];
    end
  end

  assign in_ready = !rst && adv[0];

  // Candidate contents for every pipeline register and the final result.
  always_comb begin
    stage_d[0].valid = in_valid && in_ready;
    stage_d[0].carry = sub ? !cin : cin;
    stage_d[0].sum   = '0;
    stage_d[0].a     = a;
    stage_d[0].b     = sub ? ~b : b;
    for (int k = 1; k < NS; k++) begin
      stage_d[k]                      = stage_q[k-1];
      stage_d[k].sum[(k-1)*SW +: SW] = res_sum[k-1];
      stage_d[k].carry               = res_cout[k-1];
    end
    fin_sum                     = stage_q[NS-1].sum;
    fin_sum[(NS-1)*SW +: SW]    = res_sum[NS-1];
  end

  // Pipeline and output registers; output data only changes when a new result
  // lands, so it stays stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NS; k++) stage_q[k] <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (adv[k]) stage_q[k] <= stage_d[k];
      end
      if (adv[NS]) begin
        out_valid_q <= stage_q[NS-1].valid;
        if (stage_q[NS-1].valid) begin
          sum_q  <= fin_sum;
          cout_q <= res_cout[NS-1];
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

`ifdef CSA_PIPE_OVF_EN
  logic ovf_q;

  // Signed overflow: operands agree in sign but the result does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv[NS] && stage_q[NS-1].valid) begin
      ovf_q <= (stage_q[NS-1].a[WIDTH-1] == stage_q[NS-1].b[WIDTH-1]) &&
               (fin_sum[WIDTH-1] != stage_q[NS-1].a[WIDTH-1]);
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Bench for csa_pipe_adder at default parameters: directed steps plus random
// traffic, scored against an arithmetic model of each accepted beat.
module tb_csa_pipe_adder;

  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
  logic [31:0] a, b, sum;
`ifdef CSA_PIPE_OVF_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  csa_pipe_adder dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef CSA_PIPE_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  bit          chk_lat = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] hold_sum;
  logic        hold_cout;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Plain integer arithmetic: add is a+b+cin, subtract is a-b-cin with cout=no-borrow.
  function automatic exp_t model(input logic [31:0] xa, input logic [31:0] xb,
                                 input logic xcin, input logic xsub, input int acc);
    exp_t   e;
    longint ua, ub, c, sa, sb, r, sr;
    ua = longint'(xa);
    ub = longint'(xb);
    c  = longint'(xcin);
    sa = longint'($signed(xa));
    sb = longint'($signed(xb));
    if (!xsub) begin
      r      = ua + ub + c;
      sr     = sa + sb + c;
      e.cout = r[32];
    end else begin
      r      = ua - ub - c;
      sr     = sa - sb - c;
      e.cout = (r >= 0);
    end
    e.sum = r[31:0];
    e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.acc = acc;
    return e;
  endfunction

  // One clock: score handshakes at the falling edge, then advance past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (stall_prev) begin
      check("hold_valid", out_valid, 1);
      check("hold_sum", sum, hold_sum);
      check("hold_cout", cout, hold_cout);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        e = q.pop_front();
        check("sum", sum, e.sum);
        check("cout", cout, e.cout);
`ifdef CSA_PIPE_OVF_EN
        check("ovf", ovf, e.ovf);
`endif
        if (chk_lat) check("latency", cyc - e.acc, NS);
      end
    end
    stall_prev = out_valid && !out_ready && !rst;
    hold_sum   = sum;
    hold_cout  = cout;
    if (in_valid && in_ready) q.push_back(model(a, b, cin, sub, cyc + 1));
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic xcin,
                      input logic xsub);
    a = xa; b = xb; cin = xcin; sub = xsub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    tick();
    check("drain_empty", q.size(), 0);
    check("drain_idle", out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0;

    // Reset with in_valid high
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_sum", sum, 0);
    check("post_rst_cout", cout, 0);
`ifdef CSA_PIPE_OVF_EN
    check("post_rst_ovf", ovf, 0);
`endif

    // Full-width carry ripple, then subtract cases
    chk_lat = 1'b1;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    drain();
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    send(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
    drain();

    // Eight back-to-back beats, no back-pressure
    for (int i = 0; i < 8; i++) begin
      check("stream_in_ready", in_ready, 1);
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    drain();
    chk_lat = 1'b0;

    // Fill with the consumer stalled, hold, then release
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      tick();
    end
    #1;
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    in_valid = 1'b0;
    repeat (3) tick();
    drain();

    // Reset with three beats in flight
    out_ready = 1'b1;
    repeat (3) send_rand();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    stall_prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("flushed_out_valid", out_valid, 0);
    end

    // Random traffic with random back-pressure
    for (int i = 0; i < 300; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
